// File: rtl/precision_dac_pkg.sv
// Shared types and frame helpers for the precision DAC serial controller.
package precision_dac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SHIFT,
    S_GAP,
    S_LDAC,
    S_DONE
  } dac_state_e;

  function automatic int frame_bits(input int cmd_w, input int addr_w, input int data_w);
    return cmd_w + addr_w + data_w;
  endfunction

  // Frames are at most 64 bits; callers slice the low FRAME_BITS.
  function automatic logic [63:0] build_frame(input logic [63:0] cmd, input logic [63:0] addr,
                                              input logic [63:0] data, input int addr_w,
                                              input int data_w);
    logic [63:0] amask;
    logic [63:0] dmask;
    amask = (64'd1 << addr_w) - 64'd1;
    dmask = (64'd1 << data_w) - 64'd1;
    return (cmd << (addr_w + data_w)) | ((addr & amask) << data_w) | (data & dmask);
  endfunction

endpackage

// File: rtl/precision_dac_spi_shift.sv
// Single-frame SPI shifter: sync low for 2*SCLK_DIV*FRAME_BITS cycles, MSB first,
// data changes on the sclk rising edge so the DAC can sample on the falling edge.
module precision_dac_spi_shift #(
  parameter int FRAME_BITS = 24,
  parameter int SCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  output logic                  sync_o,
  output logic                  sclk_o,
  output logic                  sdi_o,
  output logic                  done_o
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic                  busy_q, busy_d;
  logic                  phase_q, phase_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // phase_q: 0 = sclk high half, 1 = sclk low half
  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_o  = 1'b0;
    if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        phase_d = 1'b0;
        div_d   = DIV_W'(SCLK_DIV - 1);
        bit_d   = BIT_W'(FRAME_BITS - 1);
        shreg_d = frame_i;
      end
    end else if (div_q != '0) begin
      div_d = div_q - DIV_W'(1);
    end else if (!phase_q) begin
      phase_d = 1'b1;
      div_d   = DIV_W'(SCLK_DIV - 1);
    end else if (bit_q == '0) begin
      busy_d  = 1'b0;
      phase_d = 1'b0;
      done_o  = 1'b1;
    end else begin
      phase_d = 1'b0;
      div_d   = DIV_W'(SCLK_DIV - 1);
      bit_d   = bit_q - BIT_W'(1);
      shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign sync_o = ~busy_q;
  assign sclk_o = ~(busy_q & phase_q);
  assign sdi_o  = busy_q & shreg_q[FRAME_BITS-1];

endmodule

// File: rtl/precision_dac_ctrl.sv
// Multi-channel precision DAC updater: one SPI frame per channel, then a shared LDAC pulse.
// Define PRECISION_DAC_SKIP_UNCHANGED_EN to skip channels whose code was already sent.
//
//   state    | meaning
//   IDLE     | ready, waiting for valid
//   SELECT   | find next channel to send from idx_q
//   SHIFT    | serialiser busy with one frame
//   GAP      | sync high between frames (SELECT supplies the last gap cycle)
//   LDAC     | ldac low for LDAC_WIDTH cycles
//   DONE     | one cycle before returning to IDLE
module precision_dac_ctrl
  import precision_dac_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CMD_WIDTH  = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int SCLK_DIV   = 4,
  parameter int SYNC_GAP   = 2,
  parameter int LDAC_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*DATA_WIDTH-1:0] data,
  input  logic [CMD_WIDTH-1:0]       cmd,
  input  logic                       valid,
  output logic                       ready,
  output logic                       sync,
  output logic                       sclk,
  output logic                       sdi,
  output logic                       ldac
);

  localparam int FRAME_BITS = frame_bits(CMD_WIDTH, ADDR_WIDTH, DATA_WIDTH);
  localparam int IDX_W      = $clog2(N_CH + 1);
  localparam int CNT_MAX    = (SYNC_GAP > LDAC_WIDTH) ? SYNC_GAP : LDAC_WIDTH;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
`ifdef PRECISION_DAC_SKIP_UNCHANGED_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  if (N_CH > (1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("precision_dac_ctrl: N_CH does not fit in ADDR_WIDTH");
  end
  if (FRAME_BITS > 64) begin : g_bad_frame
    $error("precision_dac_ctrl: frame wider than 64 bits");
  end

  dac_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]             cmd_q, cmd_d;
  logic [N_CH-1:0][DATA_WIDTH-1:0]  data_q, data_d, shadow_q, shadow_d;
  logic [N_CH-1:0]                  sent_q, sent_d, need_send;
  logic                             any_q, any_d;
  logic                             found;
  logic [IDX_W-1:0]                 found_idx;
  logic [DATA_WIDTH-1:0]            found_data;
  logic                             shift_start, shift_done;
  logic [FRAME_BITS-1:0]            shift_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      any_q   <= any_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q    <= cmd_d;
    data_q   <= data_d;
    shadow_q <= shadow_d;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      need_send[i] = !SKIP_EN || !sent_q[i] || (data_q[i] != shadow_q[i]);
    end
  end

  // Descending loop so the lowest eligible channel at or above idx_q wins.
  always_comb begin
    found      = 1'b0;
    found_idx  = '0;
    found_data = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i >= int'(idx_q) && need_send[i]) begin
        found      = 1'b1;
        found_idx  = IDX_W'(i);
        found_data = data_q[i];
      end
    end
  end

  assign shift_frame = FRAME_BITS'(build_frame(64'(cmd_q), 64'(found_idx), 64'(found_data),
                                               ADDR_WIDTH, DATA_WIDTH));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    shadow_d    = shadow_q;
    sent_d      = sent_q;
    any_d       = any_q;
    shift_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid && ready) begin
          data_d  = data;
          cmd_d   = cmd;
          idx_d   = '0;
          any_d   = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (found) begin
          shift_start = 1'b1;
          idx_d       = found_idx;
          state_d     = S_SHIFT;
        end else if (any_q) begin
          cnt_d   = CNT_W'(LDAC_WIDTH - 1);
          state_d = S_LDAC;
        end else begin
          state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        if (shift_done) begin
          for (int i = 0; i < N_CH; i++) begin
            if (int'(idx_q) == i) begin
              shadow_d[i] = data_q[i];
              sent_d[i]   = 1'b1;
            end
          end
          any_d = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (SYNC_GAP > 1) begin
            cnt_d   = CNT_W'(SYNC_GAP - 2);
            state_d = S_GAP;
          end else begin
            state_d = S_SELECT;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_SELECT;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_LDAC: begin
        if (cnt_q == '0) state_d = S_DONE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready = (state_q == S_IDLE) && !rst;
  assign ldac  = (state_q != S_LDAC);

  precision_dac_spi_shift #(
    .FRAME_BITS(FRAME_BITS),
    .SCLK_DIV  (SCLK_DIV)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start_i(shift_start),
    .frame_i(shift_frame),
    .sync_o (sync),
    .sclk_o (sclk),
    .sdi_o  (sdi),
    .done_o (shift_done)
  );

endmodule
